// File: rtl/jt1943_obj_pkg.sv
// Shared definitions for the 1943 object (sprite) pipeline.
// Used by the per-line scanner and by the sprite drawer, so the rule that
// decides whether a sprite covers a given line exists in exactly one place.
//  - byte offsets inside a 4-byte object record
//  - blank-slot Y value, number of line-buffer slots, Y offset of the hardware
//  - scanner state encoding
//  - obj_vmatch(): vertical visibility test
//  - blank_byte(): byte returned by an empty line-buffer slot
package jt1943_obj_pkg;

    localparam int CODE_LO = 0;
    localparam int ATTR    = 1;
    localparam int YPOS    = 2;
    localparam int XPOS    = 3;

    localparam logic [7:0] BLANK_Y  = 8'hF8;
    localparam int         SLOTS    = 32;
    localparam logic [7:0] Y_OFFSET = 8'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RDY  = 3'd1,
        ST_YCHK = 3'd2,
        ST_COPY = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } scan_state_t;

    // A sprite is 16 lines tall starting at Y-2. Positions at F0 and above
    // are parked off-screen and never match, which also keeps objy+16
    // from wrapping inside the compare.
    function automatic logic obj_vmatch(input logic [7:0] vn, input logic [7:0] ybyte);
        logic [7:0] objy;
        logic [7:0] objy_end;
        objy     = ybyte - Y_OFFSET;
        objy_end = objy + 8'd16;
        return (objy < 8'hF0) && (vn >= objy) && (vn < objy_end);
    endfunction

    // Empty slots read as Y=blank_y with every other byte zero.
    function automatic logic [7:0] blank_byte(input logic [1:0] sel, input logic [7:0] blank_y);
        logic [7:0] res;
        case (sel)
            2'(CODE_LO): res = 8'h00;
            2'(ATTR):    res = 8'h00;
            2'(YPOS):    res = blank_y;
            2'(XPOS):    res = 8'h00;
            default:     res = 8'h00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/jtgng_dual_ram.sv
// Simple dual-port RAM: port A writes, port B reads with a registered output.
//  clk     in   clock shared by both ports
//  addr_a  in   aw   write address
//  data_a  in   dw   write data
//  we_a    in   1    write enable
//  cen_b   in   1    read clock enable
//  addr_b  in   aw   read address
//  q_b     out  dw   read data, updated on clk edges with cen_b=1
module jtgng_dual_ram #(
    parameter int dw = 8,
    parameter int aw = 8
) (
    input  logic          clk,
    input  logic [aw-1:0] addr_a,
    input  logic [dw-1:0] data_a,
    input  logic          we_a,
    input  logic          cen_b,
    input  logic [aw-1:0] addr_b,
    output logic [dw-1:0] q_b
);

    logic [dw-1:0] mem [0:(1<<aw)-1];

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        if (cen_b) q_b <= mem[addr_b];
    end

endmodule

// File: rtl/jt1943_objscan.sv
// Per-line sprite scanner and double line buffer.
// While line N is displayed, object RAM is walked and every sprite visible on
// line N+1 has its 4 attribute bytes copied into the write bank. The drawer
// reads the other bank through objcnt/pxlcnt. Banks swap on HINIT.
// Slots fill from 31 downwards; sprite 0 lands in slot 31 and is drawn last.
//  clk           in   system clock
//  rst           in   synchronous active-high reset
//  cen6          in   pixel enable for the read side
//  HINIT         in   start-of-line strobe (restarts the scan, swaps banks)
//  V             in   current line; the scan targets V+1
//  obj_ram_addr  out  object RAM read address (RAM has 1-clk latency)
//  obj_ram_data  in   object RAM data
//  objcnt        in   drawer slot index (slot 0 always blank)
//  pxlcnt        in   drawer pixel count, [1:0] picks the attribute byte
//  objbuf_data   out  attribute byte for the drawer, 1 cen6 after objcnt/pxlcnt
//  scan_busy     out  scan in progress
//  line_ovf      out  more than 31 sprites matched the last scan
//  st_dbg        out  scanner state, for observation only
module jt1943_objscan #(
    parameter int         OBJMAX  = 128,
    parameter int         RAMW    = 9,
    parameter logic [7:0] BLANK_Y = jt1943_obj_pkg::BLANK_Y
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen6,
    input  logic            HINIT,
    input  logic [7:0]      V,
    output logic [RAMW-1:0] obj_ram_addr,
    input  logic [7:0]      obj_ram_data,
    input  logic [4:0]      objcnt,
    input  logic [3:0]      pxlcnt,
    output logic [7:0]      objbuf_data,
    output logic            scan_busy,
    output logic            line_ovf,
    output logic [2:0]      st_dbg
);
    import jt1943_obj_pkg::*;

    localparam int IDXW = RAMW - 2;

    scan_state_t     state, state_nxt;
    logic            rd_bank;
    logic            wr_bank;
    logic [7:0]      vn;
    logic [IDXW-1:0] idx;
    logic [4:0]      slot;
    logic [1:0]      b;
    logic            copy_ph;     // 0: address issued, 1: data valid and written
    logic [5:0]      lo_slot [2]; // lowest valid slot per bank, SLOTS = empty
    logic            y_match;
    logic            last_obj;
    logic            buf_we;
    logic [7:0]      buf_q;
    logic            rd_blank;
    logic [7:0]      rd_blank_byte;
    logic [1:0]      unused_pxl;

    assign wr_bank    = ~rd_bank;
    assign y_match    = obj_vmatch(vn, obj_ram_data);
    assign last_obj   = (idx == IDXW'(OBJMAX - 1));
    assign unused_pxl = pxlcnt[3:2];

    // ---------------- scan FSM ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = ST_IDLE;
            ST_RDY:  state_nxt = ST_YCHK;
            // With slot 0 reached, a match is only recorded as overflow.
            ST_YCHK: state_nxt = (y_match && slot != 5'd0) ? ST_COPY : ST_NEXT;
            ST_COPY: state_nxt = (copy_ph && b == 2'd3) ? ST_NEXT : ST_COPY;
            ST_NEXT: state_nxt = last_obj ? ST_DONE : ST_RDY;
            ST_DONE: state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
        if (HINIT) state_nxt = ST_RDY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rd_bank    <= 1'b0;
            lo_slot[0] <= 6'(SLOTS);
            lo_slot[1] <= 6'(SLOTS);
            vn         <= 8'd0;
            idx        <= '0;
            slot       <= 5'd31;
            b          <= 2'd0;
            copy_ph    <= 1'b0;
            line_ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (HINIT) begin
                // The current read bank becomes the next write bank.
                rd_bank          <= ~rd_bank;
                lo_slot[rd_bank] <= 6'(SLOTS);
                vn               <= V + 8'd1;
                idx              <= '0;
                slot             <= 5'd31;
                b                <= 2'd0;
                copy_ph          <= 1'b0;
                line_ovf         <= 1'b0;
            end else begin
                case (state)
                    ST_YCHK: begin
                        b       <= 2'd0;
                        copy_ph <= 1'b0;
                        if (y_match && slot == 5'd0) line_ovf <= 1'b1;
                    end
                    ST_COPY: begin
                        copy_ph <= ~copy_ph;
                        if (copy_ph) begin
                            b <= b + 2'd1;
                            // The slot only becomes visible once all 4 bytes are in,
                            // so an aborted copy never shows a half-written sprite.
                            if (b == 2'd3) begin
                                lo_slot[wr_bank] <= {1'b0, slot};
                                slot             <= slot - 5'd1;
                            end
                        end
                    end
                    ST_NEXT: begin
                        if (!last_obj) idx <= idx + IDXW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign obj_ram_addr = {idx, (state == ST_RDY) ? 2'(YPOS) : b};
    assign scan_busy    = (state == ST_RDY) || (state == ST_YCHK) ||
                          (state == ST_COPY) || (state == ST_NEXT);
    assign st_dbg       = state;

    // ---------------- line buffer ----------------
    assign buf_we = (state == ST_COPY) && copy_ph && !HINIT;

    jtgng_dual_ram #(.dw(8), .aw(8)) u_buf (
        .clk    (clk),
        .addr_a ({wr_bank, slot, b}),
        .data_a (obj_ram_data),
        .we_a   (buf_we),
        .cen_b  (cen6),
        .addr_b ({rd_bank, objcnt, pxlcnt[1:0]}),
        .q_b    (buf_q)
    );

    // The blank decision is registered alongside the RAM read so both
    // paths carry the same single-cen6 latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_blank      <= 1'b1;
            rd_blank_byte <= 8'h00;
        end else if (cen6) begin
            rd_blank      <= (objcnt == 5'd0) || ({1'b0, objcnt} < lo_slot[rd_bank]);
            rd_blank_byte <= blank_byte(pxlcnt[1:0], BLANK_Y);
        end
    end

    assign objbuf_data = rd_blank ? rd_blank_byte : buf_q;

endmodule

// File: tb/tb_jt1943_objscan.sv
module tb_jt1943_objscan;
  import jt1943_obj_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       cen6 = 1'b0;
  logic [1:0] cen_cnt = 2'd0;
  logic       HINIT;
  logic [7:0] V;
  logic [8:0] obj_ram_addr;
  logic [7:0] obj_ram_data = 8'h00;
  logic [4:0] objcnt;
  logic [3:0] pxlcnt;
  logic [7:0] objbuf_data;
  logic       scan_busy;
  logic       line_ovf;
  logic [2:0] st_dbg;

  always #10 clk = ~clk;

  // cen6 changes on the falling edge: high for one clk in every four
  always @(negedge clk) begin
    cen_cnt <= cen_cnt + 2'd1;
    cen6    <= (cen_cnt == 2'd3);
  end

  // object RAM model, 1-clk synchronous read
  logic [7:0] obj_mem [512];
  always @(posedge clk) obj_ram_data <= obj_mem[obj_ram_addr];

  jt1943_objscan dut (
    .clk          (clk),
    .rst          (rst),
    .cen6         (cen6),
    .HINIT        (HINIT),
    .V            (V),
    .obj_ram_addr (obj_ram_addr),
    .obj_ram_data (obj_ram_data),
    .objcnt       (objcnt),
    .pxlcnt       (pxlcnt),
    .objbuf_data  (objbuf_data),
    .scan_busy    (scan_busy),
    .line_ovf     (line_ovf),
    .st_dbg       (st_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 512; i++) obj_mem[i] = 8'h00;
  endtask

  task automatic set_obj(input int idx, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] y, input logic [7:0] b3);
    obj_mem[idx*4+0] = b0;
    obj_mem[idx*4+1] = b1;
    obj_mem[idx*4+2] = y;
    obj_mem[idx*4+3] = b3;
  endtask

  task automatic pulse_hinit(input logic [7:0] v);
    @(negedge clk);
    V     = v;
    HINIT = 1'b1;
    @(negedge clk);
    HINIT = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (scan_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("scan_done", {31'd0, scan_busy}, 32'd0);
  endtask

  // present objcnt/pxlcnt, wait for one cen6 edge, sample just after it
  task automatic read_slot(input logic [4:0] s, input logic [1:0] sel, output logic [7:0] d);
    int n = 0;
    @(negedge clk);
    objcnt = s;
    pxlcnt = {2'b00, sel};
    do begin
      @(posedge clk);
      n++;
    end while (!cen6 && n < 16);
    #1 d = objbuf_data;
  endtask

  task automatic expect_byte(input string name, input logic [4:0] s, input logic [1:0] sel);
    logic [7:0] d;
    logic [7:0] e;
    read_slot(s, sel, d);
    e = exp_q.pop_front();
    chk($sformatf("%s slot%0d b%0d", name, s, sel), {24'd0, d}, {24'd0, e});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         idx;
    logic [7:0] b0, b1, y, b3;
    logic [7:0] v;
    logic       exp_match;
  } vvec_t;

  vvec_t vec [9];
  logic [7:0] blank [4];
  logic [7:0] d;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    blank[0] = 8'h00; blank[1] = 8'h00; blank[2] = 8'hF8; blank[3] = 8'h00;

    vec[0] = '{idx: 0,   b0: 8'h12, b1: 8'h34, y: 8'h62, b3: 8'h40, v: 8'h5F, exp_match: 1'b1};
    vec[1] = '{idx: 0,   b0: 8'h12, b1: 8'h34, y: 8'h52, b3: 8'h40, v: 8'h5F, exp_match: 1'b0};
    vec[2] = '{idx: 0,   b0: 8'h12, b1: 8'h34, y: 8'hF4, b3: 8'h40, v: 8'hF4, exp_match: 1'b0};
    vec[3] = '{idx: 5,   b0: 8'h12, b1: 8'h34, y: 8'h58, b3: 8'h40, v: 8'h5F, exp_match: 1'b1};
    vec[4] = '{idx: 0,   b0: 8'h21, b1: 8'h43, y: 8'h53, b3: 8'h65, v: 8'h5F, exp_match: 1'b1};
    vec[5] = '{idx: 0,   b0: 8'h21, b1: 8'h43, y: 8'h02, b3: 8'h65, v: 8'hFF, exp_match: 1'b1};
    vec[6] = '{idx: 0,   b0: 8'h21, b1: 8'h43, y: 8'hF1, b3: 8'h65, v: 8'hEE, exp_match: 1'b1};
    vec[7] = '{idx: 0,   b0: 8'h21, b1: 8'h43, y: 8'h01, b3: 8'h65, v: 8'hFE, exp_match: 1'b0};
    vec[8] = '{idx: 127, b0: 8'h77, b1: 8'h88, y: 8'h70, b3: 8'h99, v: 8'h6F, exp_match: 1'b1};

    // reset
    rst = 1'b1; HINIT = 1'b0; V = 8'h00; objcnt = 5'd0; pxlcnt = 4'd0;
    clear_mem();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst objbuf_data", {24'd0, objbuf_data}, 32'h00);
    chk("rst scan_busy", {31'd0, scan_busy}, 32'd0);
    chk("rst line_ovf", {31'd0, line_ovf}, 32'd0);
    chk("rst obj_ram_addr", {23'd0, obj_ram_addr}, 32'd0);
    chk("rst state", {29'd0, st_dbg}, {29'd0, ST_IDLE});
    exp_q.push_back(8'hF8); expect_byte("rst blank", 5'd5, 2'd2);
    exp_q.push_back(8'h00); expect_byte("rst blank", 5'd31, 2'd0);

    // all Y=00: nothing matches, every slot blank
    pulse_hinit(8'h7F);
    chk("t1 busy after hinit", {31'd0, scan_busy}, 32'd1);
    wait_idle();
    chk("t1 line_ovf", {31'd0, line_ovf}, 32'd0);
    pulse_hinit(8'h7F);
    for (int s = 0; s < 32; s++)
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(blank[k]);
        expect_byte("t1", 5'(s), 2'(k));
      end

    // vertical match table
    for (int i = 0; i < 9; i++) begin
      clear_mem();
      set_obj(vec[i].idx, vec[i].b0, vec[i].b1, vec[i].y, vec[i].b3);
      pulse_hinit(vec[i].v);
      wait_idle();
      chk($sformatf("vec%0d line_ovf", i), {31'd0, line_ovf}, 32'd0);
      pulse_hinit(vec[i].v);
      exp_q.push_back(vec[i].exp_match ? vec[i].b0 : blank[0]);
      exp_q.push_back(vec[i].exp_match ? vec[i].b1 : blank[1]);
      exp_q.push_back(vec[i].exp_match ? vec[i].y  : blank[2]);
      exp_q.push_back(vec[i].exp_match ? vec[i].b3 : blank[3]);
      for (int k = 0; k < 4; k++) expect_byte($sformatf("vec%0d", i), 5'd31, 2'(k));
      exp_q.push_back(8'hF8);
      expect_byte($sformatf("vec%0d", i), 5'd30, 2'd2);
    end

    // 40 matching sprites: 31 copied, overflow flagged
    clear_mem();
    for (int i = 0; i < 40; i++) set_obj(i, 8'(i), 8'h55, 8'h62, 8'(8'h80 + i));
    pulse_hinit(8'h5F);
    wait_idle();
    chk("t4 line_ovf set", {31'd0, line_ovf}, 32'd1);
    pulse_hinit(8'h5F);
    chk("t4 line_ovf cleared", {31'd0, line_ovf}, 32'd0);
    for (int k = 0; k < 31; k++) begin
      exp_q.push_back(8'(k));
      expect_byte("t4", 5'(31 - k), 2'd0);
    end
    exp_q.push_back(8'h9E); expect_byte("t4", 5'd1, 2'd3);
    exp_q.push_back(8'hF8); expect_byte("t4", 5'd0, 2'd2);

    // abort after three complete copies (each matched sprite takes 11 clks)
    clear_mem();
    for (int i = 0; i < 10; i++) set_obj(i, 8'(8'hA0 + i), 8'h11, 8'h62, 8'(8'hC0 + i));
    pulse_hinit(8'h5F);
    repeat (35) @(negedge clk);
    pulse_hinit(8'h5F);
    chk("t5 busy reasserted", {31'd0, scan_busy}, 32'd1);
    chk("t5 state", {29'd0, st_dbg}, {29'd0, ST_RDY});
    chk("t5 addr idx0", {23'd0, obj_ram_addr}, 32'd2);
    exp_q.push_back(8'hA0); expect_byte("t5", 5'd31, 2'd0);
    exp_q.push_back(8'hA1); expect_byte("t5", 5'd30, 2'd0);
    exp_q.push_back(8'hA2); expect_byte("t5", 5'd29, 2'd0);
    exp_q.push_back(8'hC2); expect_byte("t5", 5'd29, 2'd3);
    exp_q.push_back(8'hF8); expect_byte("t5", 5'd28, 2'd2);
    exp_q.push_back(8'h00); expect_byte("t5", 5'd28, 2'd0);
    exp_q.push_back(8'hF8); expect_byte("t5", 5'd1, 2'd2);

    // drawer sweep while the next scan is writing the other bank
    chk("t6 busy during sweep", {31'd0, scan_busy}, 32'd1);
    for (int s = 0; s < 32; s++) begin
      exp_q.push_back((s >= 29) ? 8'(8'hA0 + (31 - s)) : 8'h00);
      expect_byte("t6", 5'(s), 2'd0);
      exp_q.push_back((s >= 29) ? 8'h62 : 8'hF8);
      expect_byte("t6", 5'(s), 2'd2);
    end

    // exactly one cen6 of latency: value holds on a non-cen edge
    read_slot(5'd31, 2'd0, d);
    chk("t6 lat pre", {24'd0, d}, 32'hA0);
    @(negedge clk);
    objcnt = 5'd30;
    @(posedge clk);
    #1 chk("t6 lat hold", {24'd0, objbuf_data}, 32'hA0);
    begin
      int n = 0;
      while (!cen6 && n < 8) begin
        @(posedge clk);
        n++;
      end
      if (cen6 && n == 0) @(posedge clk);
    end
    #1 chk("t6 lat one cen6", {24'd0, objbuf_data}, 32'hA1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
